// File: rtl/alu_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_ram_ctrl_if
// Request/acknowledge bus between the ALU and its byte-addressed memory.
//   ramAddress : byte address of the access (ALU -> memory)
//   ramIn      : write data (ALU -> memory)
//   readReq    : read request, level (ALU -> memory)
//   writeReq   : write request, level (ALU -> memory)
//   ramValue   : registered read data (memory -> ALU)
//   readAck    : one-cycle pulse, ramValue valid (memory -> ALU)
//   writeAck   : one-cycle pulse, write committed (memory -> ALU)
//   rangeErr   : sticky out-of-range flag (memory -> ALU)
// master = ALU side, slave = memory side.
// ---------------------------------------------------------------------------
interface alu_ram_ctrl_if;
    logic [31:0] ramAddress;
    logic [31:0] ramIn;
    logic        readReq;
    logic        writeReq;
    logic [31:0] ramValue;
    logic        readAck;
    logic        writeAck;
    logic        rangeErr;

    modport master (
        output ramAddress, ramIn, readReq, writeReq,
        input  ramValue, readAck, writeAck, rangeErr
    );

    modport slave (
        input  ramAddress, ramIn, readReq, writeReq,
        output ramValue, readAck, writeAck, rangeErr
    );
endinterface

// File: rtl/alu_ram_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ram_ctrl
// Byte-addressed data/instruction memory serving the ALU read/write
// handshake. 32-bit words are stored little-endian over four consecutive
// bytes; byte indices wrap modulo RAMSIZE, unaligned accesses are legal.
// WAIT_CYCLES extra cycles can be inserted between acceptance and access.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset (memory contents are kept)
//   bus   : alu_ram_ctrl_if.slave (ramAddress, ramIn, readReq, writeReq,
//           ramValue, readAck, writeAck, rangeErr)
//
// Optional feature macro: MEM_RANGE_CHECK_EN
//   Defined   : addresses >= RAMSIZE-3 (full 32-bit compare) are out of
//               range; reads return 32'hDEADBEEF, writes are dropped but
//               still acknowledged, and rangeErr sticks high until reset.
//   Undefined : rangeErr stays 0 and all addresses wrap.
// ---------------------------------------------------------------------------
module alu_ram_ctrl #(
    parameter int RAMSIZE     = 2048,
    parameter int ADDR_BITS   = 11,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          reset,
    alu_ram_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Counter preload so that the ACCESS state is reached WAIT_CYCLES
    // cycles after acceptance.
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] OOR_DATA  = 32'hDEADBEEF;

    state_t                state_r;
    state_t                next_state_s;
    logic [7:0]            mem_r [RAMSIZE];
    logic [ADDR_BITS-1:0]  addr_r;
    logic [31:0]           wdata_r;
    logic                  op_write_r;
    logic                  oor_r;
    logic [3:0]            wait_cnt_r;
    logic [31:0]           ram_value_r;
    logic                  read_ack_r;
    logic                  write_ack_r;
    logic                  range_err_r;
    logic [31:0]           ram_value_nxt_s;
    logic                  read_ack_nxt_s;
    logic                  write_ack_nxt_s;
    logic                  range_err_nxt_s;
    logic                  mem_we_s;
    logic [31:0]           rd_word_s;
    logic                  accept_s;
    logic                  oor_s;

`ifdef MEM_RANGE_CHECK_EN
    localparam logic [31:0] OOR_LIMIT = 32'(RAMSIZE - 3);
    // Full-width compare: upper address bits count, no wrap.
    assign oor_s = (bus.ramAddress >= OOR_LIMIT);
`else
    logic unused_addr_bits_s;
    assign oor_s              = 1'b0;
    assign unused_addr_bits_s = ^bus.ramAddress[31:ADDR_BITS];
`endif

    // Any ack in the previous cycle blocks acceptance so the ALU can drop
    // its still-high request level (turnaround cycle).
    assign accept_s = (state_r == ST_IDLE) && (bus.readReq || bus.writeReq)
                      && !read_ack_r && !write_ack_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_ACCESS: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            op_write_r <= 1'b0;
            oor_r      <= 1'b0;
            wait_cnt_r <= 4'd0;
        end else if (accept_s) begin
            addr_r     <= bus.ramAddress[ADDR_BITS-1:0];
            wdata_r    <= bus.ramIn;
            op_write_r <= bus.writeReq;  // write wins when both are high
            oor_r      <= oor_s;
            wait_cnt_r <= WAIT_INIT;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Little-endian word gather; the index add wraps at RAMSIZE naturally.
    always_comb begin
        rd_word_s = 32'd0;
        for (int k = 0; k < 4; k++) begin
            rd_word_s[8*k +: 8] = mem_r[addr_r + ADDR_BITS'(k)];
        end
    end

    // Output/next-value logic for the ACCESS state.
    always_comb begin
        ram_value_nxt_s = ram_value_r;
        read_ack_nxt_s  = 1'b0;
        write_ack_nxt_s = 1'b0;
        range_err_nxt_s = range_err_r;
        mem_we_s        = 1'b0;
        case (state_r)
            ST_ACCESS: begin
                if (op_write_r) begin
                    write_ack_nxt_s = 1'b1;
                    mem_we_s        = !oor_r;
                end else begin
                    read_ack_nxt_s  = 1'b1;
                    ram_value_nxt_s = oor_r ? OOR_DATA : rd_word_s;
                end
                range_err_nxt_s = range_err_r | oor_r;
            end
            default: begin
                ram_value_nxt_s = ram_value_r;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_value_r <= 32'd0;
            read_ack_r  <= 1'b0;
            write_ack_r <= 1'b0;
            range_err_r <= 1'b0;
        end else begin
            ram_value_r <= ram_value_nxt_s;
            read_ack_r  <= read_ack_nxt_s;
            write_ack_r <= write_ack_nxt_s;
            range_err_r <= range_err_nxt_s;
        end
    end

    // Byte array write; not cleared by reset, and a reset sampled on the
    // ACCESS edge cancels the commit.
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            for (int k = 0; k < 4; k++) begin
                mem_r[addr_r + ADDR_BITS'(k)] <= wdata_r[8*k +: 8];
            end
        end
    end

    assign bus.ramValue = ram_value_r;
    assign bus.readAck  = read_ack_r;
    assign bus.writeAck = write_ack_r;
    assign bus.rangeErr = range_err_r;

endmodule

// File: tb/tb_alu_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_ram_ctrl
// Self-checking bench for alu_ram_ctrl. Two instances (WAIT_CYCLES 0 and 3)
// share one stimulus driver; a byte-array reference model predicts read
// data, ack latency and the sticky range flag.
// ---------------------------------------------------------------------------
module tb_alu_ram_ctrl;

    localparam int RS = 2048;
`ifdef MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst3;
    logic [31:0] b_addr;
    logic [31:0] b_in;
    logic        b_rd;
    logic        b_wr;
    int          sel;
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  mm [2][RS];
    logic [31:0] last_rv [2];
    logic        exp_err [2];

    always #5 clk = ~clk;

    alu_ram_ctrl_if if0 ();
    alu_ram_ctrl_if if3 ();

    assign if0.ramAddress = b_addr;
    assign if0.ramIn      = b_in;
    assign if0.readReq    = b_rd && (sel == 0);
    assign if0.writeReq   = b_wr && (sel == 0);
    assign if3.ramAddress = b_addr;
    assign if3.ramIn      = b_in;
    assign if3.readReq    = b_rd && (sel != 0);
    assign if3.writeReq   = b_wr && (sel != 0);

    alu_ram_ctrl #(.RAMSIZE(2048), .ADDR_BITS(11), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst0), .bus(if0.slave));
    alu_ram_ctrl #(.RAMSIZE(2048), .ADDR_BITS(11), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst3), .bus(if3.slave));

    logic        rack;
    logic        wack;
    logic        rerr;
    logic [31:0] rval;
    assign rack = (sel != 0) ? if3.readAck  : if0.readAck;
    assign wack = (sel != 0) ? if3.writeAck : if0.writeAck;
    assign rerr = (sel != 0) ? if3.rangeErr : if0.rangeErr;
    assign rval = (sel != 0) ? if3.ramValue : if0.ramValue;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return RC && (a >= 32'(RS - 3));
    endfunction

    function automatic logic [31:0] model_read(input int s, input logic [31:0] a);
        logic [31:0] w;
        w = 32'd0;
        if (is_oor(a)) return 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mm[s][int'((a + 32'(k)) % 32'(RS))];
        return w;
    endfunction

    function automatic void model_write(input int s, input logic [31:0] a, input logic [31:0] d);
        if (!is_oor(a)) begin
            for (int k = 0; k < 4; k++) mm[s][int'((a + 32'(k)) % 32'(RS))] = d[8*k +: 8];
        end
    endfunction

    // One ALU transaction; the request is presented after an idle cycle so
    // the first edge is the acceptance edge.
    task automatic access(input int s, input bit wr, input bit both, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, output logic [31:0] rv);
        int          n;
        bit          got;
        int          w;
        logic [31:0] exp;
        w = (s != 0) ? 3 : 0;
        @(negedge clk);
        sel = s; b_addr = a; b_in = d;
        b_wr = wr || both;
        b_rd = !wr || both;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) b_in = ~d;  // must not affect the latched data
            if (rack || wack) got = 1'b1;
        end
        check("ack_seen", 32'(got), 32'd1);
        check("ack_latency", 32'(n), 32'(2 + w));
        if (wr || both) begin
            check("wack", 32'(wack), 32'd1);
            check("no_rack_on_write", 32'(rack), 32'd0);
            check("rv_hold_on_write", rval, last_rv[s]);
            model_write(s, a, d);
        end else begin
            check("rack", 32'(rack), 32'd1);
            check("no_wack_on_read", 32'(wack), 32'd0);
            exp = model_read(s, a);
            check("rd_data", rval, exp);
            last_rv[s] = exp;
        end
        if (is_oor(a)) exp_err[s] = 1'b1;
        check("range_err", 32'(rerr), 32'(exp_err[s]));
        rv = rval;
        if (!hold) begin
            b_rd = 1'b0; b_wr = 1'b0;
        end
        @(posedge clk); #1;
        check("ack_pulse", 32'({rack, wack}), 32'd0);
        b_rd = 1'b0; b_wr = 1'b0;
        if (hold) begin
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                check("turnaround", 32'({rack, wack}), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] a;
        int          r;
        int          s;
        rst0 = 1'b1; rst3 = 1'b1;
        b_addr = 32'd0; b_in = 32'd0; b_rd = 1'b0; b_wr = 1'b0; sel = 0;
        for (int i = 0; i < 2; i++) begin
            last_rv[i] = 32'd0;
            exp_err[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst0_rv",   if0.ramValue, 32'd0);
        check("rst0_acks", 32'({if0.readAck, if0.writeAck, if0.rangeErr}), 32'd0);
        check("rst3_rv",   if3.ramValue, 32'd0);
        check("rst3_acks", 32'({if3.readAck, if3.writeAck, if3.rangeErr}), 32'd0);
        @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;

        // Give every byte of both memories a known value.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < RS / 4; i++) access(k, 1'b1, 1'b0, 32'(i * 4), $urandom, 1'b0, rv);
        end

        // Aligned write/read and byte order.
        access(0, 1'b1, 1'b0, 32'h100, 32'h11223344, 1'b0, rv);
        access(0, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, rv);
        check("rd100_const", rv, 32'h11223344);
        access(0, 1'b0, 1'b0, 32'h101, 32'd0, 1'b0, rv);
        check("rd101_low3", 32'(rv[23:0]), 32'h112233);

        // Unaligned read spanning two words.
        access(0, 1'b1, 1'b0, 32'h200, 32'hAABBCCDD, 1'b0, rv);
        access(0, 1'b1, 1'b0, 32'h204, 32'h01020304, 1'b0, rv);
        access(0, 1'b0, 1'b0, 32'h202, 32'd0, 1'b0, rv);
        check("rd202_const", rv, 32'h0304AABB);

        // Simultaneous requests: write wins.
        access(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, rv);
        access(0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, rv);
        check("rd10_const", rv, 32'hCAFEF00D);

        // Top-of-memory wrap / range check.
        access(0, 1'b1, 1'b0, 32'h7FE, 32'h55667788, 1'b0, rv);
        check("wrap_err", 32'(rerr), 32'(RC));
        access(0, 1'b0, 1'b0, 32'h7FE, 32'd0, 1'b0, rv);
        check("rd7fe_const", rv, RC ? 32'hDEADBEEF : 32'h55667788);
        access(0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, rv);
        access(0, 1'b0, 1'b0, 32'h1000_0100, 32'd0, 1'b0, rv);

        // Wait states with held request and turnaround.
        access(1, 1'b1, 1'b0, 32'h300, 32'h0BADF00D, 1'b0, rv);
        access(1, 1'b0, 1'b0, 32'h300, 32'd0, 1'b1, rv);
        check("rd300_const", rv, 32'h0BADF00D);
        access(0, 1'b0, 1'b0, 32'h100, 32'd0, 1'b1, rv);

        // Randomised traffic against the model.
        for (int i = 0; i < 200; i++) begin
            s = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7)      a = 32'($urandom_range(0, RS - 1));
            else if (r < 9) a = 32'($urandom_range(RS - 8, RS - 1));
            else            a = $urandom;
            access(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), a, $urandom, 1'b0, rv);
        end

        // Reset during WAIT of a write: no ack, memory unchanged.
        @(negedge clk);
        sel = 1; b_addr = 32'h40; b_in = 32'h99887766; b_wr = 1'b1;
        @(posedge clk); #1;
        b_wr = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        @(posedge clk); #1;
        check("midrst_rv",   if3.ramValue, 32'd0);
        check("midrst_outs", 32'({if3.readAck, if3.writeAck, if3.rangeErr}), 32'd0);
        last_rv[1] = 32'd0;
        exp_err[1] = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("midrst_no_ack", 32'({if3.readAck, if3.writeAck}), 32'd0);
        end
        access(1, 1'b0, 1'b0, 32'h40, 32'd0, 1'b0, rv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ram_ctrl.md
Name: alu_ram_ctrl

Overview:
Synthesizable byte-addressed data/instruction memory that serves the ALU's readReq/writeReq → readAck/writeAck handshake.
Sits directly downstream of the ALU and replaces the behavioural RAM loop used in simulation.
Stores 32-bit words little-endian over four consecutive bytes.
Supports configurable wait states for modelling slow memory.

Parameters:
RAMSIZE, 2048, memory depth in bytes; must be a power of two.
ADDR_BITS, 11, log2(RAMSIZE); low address bits used for indexing.
WAIT_CYCLES, 0, extra cycles inserted between request acceptance and access (0..15).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
ramAddress  input  32  byte address of access (from ALU)
ramIn  input  32  write data (ALU ramOut)
readReq  input  1  read request, level
writeReq  input  1  write request, level
ramValue  output  32  read data, registered
readAck  output  1  one-cycle pulse: ramValue valid
writeAck  output  1  one-cycle pulse: write committed
rangeErr  output  1  sticky range error; tied 0 unless MEM_RANGE_CHECK_EN

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: ramValue=0, readAck=0, writeAck=0, rangeErr=0, state=IDLE, wait counter=0. Memory contents are not cleared.
- States: IDLE, WAIT, ACCESS.
- IDLE, request acceptance:
  - A request is accepted if readReq or writeReq is high and both acks were 0 in the previous cycle.
  - In the cycle after any ack, requests are ignored (turnaround cycle). This lets the ALU drop its request.
- On acceptance, latch:
  - addr = ramAddress[ADDR_BITS-1:0]
  - wdata = ramIn
  - op = write if writeReq else read. Write wins if both are high.
- After acceptance: go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise go directly to ACCESS.
- WAIT: decrement the counter each cycle. Move to ACCESS on the cycle the counter is 0.
- ACCESS, read:
  - ramValue[8k+7:8k] <= mem[(addr+k) mod RAMSIZE] for k=0..3.
  - readAck <= 1.
  - Return to IDLE.
- ACCESS, write:
  - mem[(addr+k) mod RAMSIZE] <= wdata[8k+7:8k] for k=0..3.
  - writeAck <= 1.
  - Return to IDLE.
- Acks are high for exactly one cycle and clear on the next edge.
- Latency: a request sampled at edge E gives its ack visible after edge E+1+WAIT_CYCLES.
- ramValue holds its value between reads; writes never change ramValue.
- Address wrap: byte indices wrap modulo RAMSIZE. Upper ramAddress bits are ignored.
- Unaligned addresses are legal.
- Read-after-write to the same address returns the new data. The write commits at its ACCESS edge, and the earliest following read ACCESS is at least 2 cycles later.
- Reset mid-operation: the request is abandoned and no ack is issued. A write is committed only if its ACCESS edge occurred before reset was sampled high.
- ramIn changes after acceptance have no effect.

Optional Feature:
MEM_RANGE_CHECK_EN
- Defined:
  - An access is out of range if ramAddress >= RAMSIZE-3 (full 32-bit compare, no wrap).
  - An out-of-range read returns ramValue=32'hDEADBEEF with readAck.
  - An out-of-range write leaves memory unchanged but still pulses writeAck.
  - Either case sets rangeErr=1, which stays high until reset.
- Undefined: rangeErr tied 0, and all addresses wrap as above.

Test Plan:
- Write/read, WAIT_CYCLES=0:
  - Write 32'h11223344 to 0x100, then read 0x100 → ramValue=32'h11223344.
  - Bytes mem[0x100..0x103] = 44,33,22,11.
  - Each ack follows its request edge by 1 cycle and lasts exactly 1 cycle.
- Unaligned, WAIT_CYCLES=0:
  - Write 32'hAABBCCDD to 0x200 and 32'h01020304 to 0x204, then read 0x202 → 32'h0304AABB.
- Wait states, WAIT_CYCLES=3: read request held high → readAck exactly 4 cycles after the acceptance edge. The turnaround cycle admits no second request even with readReq still high.
- Simultaneous requests: readReq=writeReq=1 with ramIn=32'hCAFEF00D at 0x10 → writeAck only. A subsequent read of 0x10 returns 32'hCAFEF00D.
- Wrap/range check:
  - Without the macro: write 32'h55667788 at 0x7FE (RAMSIZE=2048) → mem[0x7FE]=88, mem[0x7FF]=77, mem[0x000]=66, mem[0x001]=55.
  - With MEM_RANGE_CHECK_EN: the same write leaves memory unchanged and sets rangeErr=1. A following read of 0x7FE returns 32'hDEADBEEF.
- Reset mid-operation, WAIT_CYCLES=2: assert reset during WAIT of a write to 0x40 → no writeAck, mem[0x40..0x43] unchanged, all outputs 0 after the reset edge.
